// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types for the memory-access pipeline stage
//
// Purpose: pipeline-register layouts and access-size/state encodings used by
//          mem_stage and load_align.
// Contents: Signal, Register, RegAddr, Size, MemState, M_ctrl, M_data,
//           M_output, decode_size().
package mem_stage_pkg;

  typedef logic        Signal;
  typedef logic [31:0] Register;
  typedef logic [4:0]  RegAddr;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } Size;

  typedef enum logic {
    MS_IDLE,
    MS_WAIT
  } MemState;

  // X/M control bundle
  typedef struct packed {
    Signal       mem_read;
    Signal       mem_write;
    logic [1:0]  size;
    Signal       ld_unsigned;
  } M_ctrl;

  // X/M data bundle
  typedef struct packed {
    RegAddr  dst;
    Register addr;
    Register val;
  } M_data;

  // M/W boundary register
  typedef struct packed {
    Signal   valid;
    RegAddr  dst;
    Register alu;
    Register ld_data;
  } M_output;

  // Raw size field to access size; the unused code 2'b11 behaves as a word.
  function automatic Size decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - load data lane select and extension
//
// Purpose: combinational extraction of a byte/half/word from a read word.
// Ports:
//   i_rdata       32-bit word returned by memory
//   i_addr_lo     low two address bits selecting the lane
//   i_size        access size
//   i_ld_unsigned 1 = zero-extend, 0 = sign-extend
//   o_ld_data     aligned, extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  Size         i_size,
  input  logic        i_ld_unsigned,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Half lane uses addr[1] only; addr[0] is ignored here by design.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    case (i_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/ready data port
//
// Purpose: issues loads/stores from the X/M register to data memory, stalls
//          upstream while memory is busy, aborts after TIMEOUT cycles, and
//          registers results into the M/W boundary.
// Optional: MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   m_ctrl/m_data X/M control and data bundles
//   dmem_*        data-memory request port (req/ready handshake)
//   stall         freezes PC and earlier pipeline registers
//   m_out         M/W register {valid, dst, alu, ld_data}
//   bus_err       one-cycle error pulse
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  m_ctrl,
  input  logic [68:0] m_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [69:0] m_out,
  output logic        bus_err
);

  M_ctrl            w_ctrl;
  M_data            w_data;
  Size              w_size;
  logic             w_access;
  logic             w_misalign;
  logic             w_issue;
  logic             w_timeout;
  logic             w_load_done;
  logic [31:0]      w_ld_data;

  MemState          r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  M_output          r_m_out;
  logic             r_bus_err;

  assign w_ctrl   = m_ctrl;
  assign w_data   = m_data;
  assign w_size   = decode_size(w_ctrl.size);
  assign w_access = w_ctrl.mem_read | w_ctrl.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access &
                      (((w_size == SZ_HALF) & w_data.addr[0]) |
                       ((w_size == SZ_WORD) & (w_data.addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Request is combinational so an immediately-ready memory costs no bubble.
  assign w_issue  = w_access & ~w_misalign & ~rst;
  assign dmem_req = w_issue;

  // Last permitted wait cycle: the access retires (aborted) instead of stalling.
  assign w_timeout = w_issue & ~dmem_ready & (r_state == MS_WAIT) &
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign stall     = w_issue & ~dmem_ready & ~w_timeout;

  // Read+write together is treated as a store, so it never returns load data.
  assign w_load_done = w_issue & dmem_ready & w_ctrl.mem_read & ~w_ctrl.mem_write;

  assign dmem_we   = w_ctrl.mem_write;
  assign dmem_addr = {w_data.addr[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = w_data.val;
    if (w_ctrl.mem_write) begin
      case (w_size)
        SZ_BYTE: begin
          dmem_be    = 4'b0001 << w_data.addr[1:0];
          dmem_wdata = {4{w_data.val[7:0]}};
        end
        SZ_HALF: begin
          dmem_be    = w_data.addr[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{w_data.val[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = w_data.val;
        end
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata       (dmem_rdata),
    .i_addr_lo     (w_data.addr[1:0]),
    .i_size        (w_size),
    .i_ld_unsigned (w_ctrl.ld_unsigned),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MS_IDLE;
      r_wait_cnt <= '0;
      r_m_out    <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= w_timeout | w_misalign;
      if (stall) begin
        // Bubble into writeback while the access is outstanding.
        r_m_out <= '0;
        if (r_state == MS_IDLE) begin
          r_state    <= MS_WAIT;
          r_wait_cnt <= CNT_W'(1);
        end else begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
      end else begin
        r_state         <= MS_IDLE;
        r_wait_cnt      <= '0;
        r_m_out.valid   <= 1'b1;
        r_m_out.dst     <= (w_ctrl.mem_write | w_misalign) ? RegAddr'(0) : w_data.dst;
        r_m_out.alu     <= w_data.addr;
        r_m_out.ld_data <= w_load_done ? w_ld_data : 32'd0;
      end
    end
  end

  assign m_out   = r_m_out;
  assign bus_err = r_bus_err;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, directly downstream of the execute/memory pipeline register.
- Consumes M_ctrl/M_data.
- Drives the data-memory port with a req/ready handshake and aligns load data.
- Stalls upstream stages while memory is busy; registers results into the memory/writeback boundary (M_output) for writeback.

Parameters:
- TIMEOUT, 16: maximum wait cycles for dmem_ready before the access is aborted with bus_err.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- m_ctrl  input  5  M_ctrl: mem_read, mem_write, size[1:0] (00 byte, 01 half, 10 word), ld_unsigned
- m_data  input  69  M_data: dst[4:0], addr[31:0], val[31:0]
- dmem_req  output  1  access request, held until accepted
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  store data replicated into lanes
- dmem_ready  input  1  memory accepts/completes the access this cycle
- dmem_rdata  input  32  read word, valid when dmem_ready=1
- stall  output  1  freeze PC, F/D, D/X and X/M registers
- m_out  output  70  M_output: valid, dst[4:0], alu[31:0], ld_data[31:0]
- bus_err  output  1  one-cycle pulse on timeout (and on misalignment when the optional feature is enabled)

Behaviour:
- Access present when mem_read|mem_write. Both set is illegal and is treated as a store.
- States are IDLE and WAIT, plus wait_cnt.
- Reset: state=IDLE, wait_cnt=0, m_out=0 (valid=0), bus_err=0.
- Reset has priority over everything and aborts any in-flight access; dmem_req is deasserted in the cycle rst is high.
- dmem_req=1 whenever an access is present and rst=0. In IDLE this is combinational in the same cycle.
- stall = dmem_req & ~dmem_ready. There is no extra bubble when memory is ready immediately.
- IDLE with access and ready=1: completes at this edge, stays IDLE.
- IDLE with access and ready=0: go to WAIT, wait_cnt=1.
- WAIT with ready=1: complete, go to IDLE, wait_cnt=0.
- WAIT with ready=0 and wait_cnt==TIMEOUT-1: abort.
  - Complete with ld_data=0, bus_err=1 for one cycle, go to IDLE.
  - stall is forced low in that cycle.
- WAIT otherwise: wait_cnt++.
- Upstream holds m_ctrl/m_data stable while stall=1. The block relies on this.
- m_out registered at every non-stalled edge, giving 1-cycle latency:
  - valid=1 when rst=0.
  - dst=m_data.dst. dst=0 on a store, because stores write no register.
  - alu=m_data.addr.
  - ld_data=aligned load value or 0.
- In a stalled cycle m_out.valid=0 and dst=0, inserting a bubble into writeback.
- Non-memory instruction: no request, passes through with ld_data=0.
- Store byte lanes:
  - byte: be=1<<addr[1:0], wdata={4{val[7:0]}}.
  - half: be=addr[1]?1100:0011, wdata={2{val[15:0]}}.
  - word: be=1111, wdata=val.
  - Loads drive be=1111.
- Load alignment:
  - Select byte addr[1:0] or half addr[1] of rdata.
  - Sign-extend unless ld_unsigned.
  - Word loads pass rdata through.
- size=11 is treated as word.
- Without the optional feature, misaligned half/word addresses ignore the low address bits.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request and raises no stall.
  - m_out retires next edge with ld_data=0 and dst=0.
  - bus_err pulses for one cycle.
- Undefined: alignment logic is absent and low address bits are silently ignored.

Decomposition:
- Package definitions gains:
  - M_output struct.
  - Size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - MemState enum (MS_IDLE, MS_WAIT).
  - Existing Signal, Register, RegAddr, M_ctrl and M_data are reused.
- Sub-module load_align is combinational: rdata, addr[1:0], size and ld_unsigned in; 32-bit ld_data out. It is reused by any future cache.

Test Plan:
- Reset then no access: m_out.valid=1 with dst from input, alu=addr, ld_data=0, stall=0, dmem_req=0.
- LW addr=0x100, ready same cycle, rdata=0xDEADBEEF: stall=0, next cycle ld_data=0xDEADBEEF, dst unchanged.
- LB addr=0x103, rdata=0x80112233, ready after 3 cycles:
  - stall=1 for 3 cycles with valid=0 bubbles.
  - Then ld_data=0xFFFFFF80.
  - LBU of the same gives 0x00000080.
- SH addr=0x202, val=0x1234ABCD: be=1100, wdata=0xABCDABCD, dmem_we=1, m_out.dst=0.
- LW with ready held low: stall high for exactly TIMEOUT-1 cycles, bus_err pulses once, ld_data=0, then IDLE.
- rst asserted during WAIT: next cycle dmem_req=0, stall=0, m_out=0, state=IDLE.
- With MEM_ALIGN_CHECK_EN, LW addr=0x102: no dmem_req, bus_err=1, dst=0.
